dpram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one port of the dual-port block RAM (one-cycle registered read, write-first) between two masters, e.g. the core's data path and the host/loader. It issues at most one RAM access per clock and steers the read data back to the requester that issued it. An optional bounded lock keeps read-modify-write sequences atomic.

---
 rtl/dpram_port_arbiter_if.sv | 30 +++
 rtl/dpram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : dpram_port_arbiter_if
// Requester-side bundle for one arbiter port: request, grant and read return.
// Rev    : 1.0
// ============================================================================
interface dpram_port_arbiter_if #(
    parameter int DATA = 8,
    parameter int ADDR = 10
);
    logic            valid;
    logic            wr;
    logic            lock;
    logic [ADDR-1:0] addr;
    logic [DATA-1:0] din;
    logic            ready;
    logic            rsp_valid;
    logic [DATA-1:0] rsp_data;

    modport master (
        output valid, wr, lock, addr, din,
        input  ready, rsp_valid, rsp_data
    );

    modport slave (
        input  valid, wr, lock, addr, din,
        output ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dpram_port_arbiter
// Shares one block-RAM port between two requesters with bounded locking.
// Rev    : 1.0
// ============================================================================
module dpram_port_arbiter #(
    parameter int DATA     = 8,
    parameter int ADDR     = 10,
    parameter int LOCK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    dpram_port_arbiter_if.slave req0,
    dpram_port_arbiter_if.slave req1,
    output logic                ram_wr,
    output logic [ADDR-1:0]     ram_addr,
    output logic [DATA-1:0]     ram_din,
    input  logic [DATA-1:0]     ram_dout
);
    localparam logic [3:0] C_LOCK_MAX = 4'(LOCK_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_t;

    owner_t     r_owner;
    owner_t     w_owner_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic [3:0] r_lock_cnt;
    logic [3:0] w_lock_cnt_nxt;
    logic       r_pend_vld;
    logic       w_pend_vld_nxt;
    logic       r_pend_id;
    logic       w_pend_id_nxt;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_forced;
    logic       w_any;
    logic       w_win_lock;
    logic       w_win_wr;
    logic       w_peer_vld;
    logic       w_idle_serve;
    logic       w_win_is_owner;
    logic [3:0] w_cnt_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= OWN_NONE;
            r_last     <= 1'b1;
            r_lock_cnt <= 4'd0;
            r_pend_vld <= 1'b0;
            r_pend_id  <= 1'b0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_id  <= w_pend_id_nxt;
        end
    end

    always_comb begin
        w_gnt0         = 1'b0;
        w_gnt1         = 1'b0;
        w_forced       = 1'b0;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_lock_cnt_nxt = r_lock_cnt;
        w_cnt_base     = 4'd0;

        if (!rst) begin
            case (r_owner)
                OWN_0: begin
                    if (req0.valid && req1.valid && r_lock_cnt == C_LOCK_MAX) begin
                        w_gnt1   = 1'b1;
                        w_forced = 1'b1;
                    end else if (req0.valid) begin
                        w_gnt0 = 1'b1;
                    end else if (req1.valid) begin
                        w_gnt1 = 1'b1;
                    end
                end
                OWN_1: begin
                    if (req0.valid && req1.valid && r_lock_cnt == C_LOCK_MAX) begin
                        w_gnt0   = 1'b1;
                        w_forced = 1'b1;
                    end else if (req1.valid) begin
                        w_gnt1 = 1'b1;
                    end else if (req0.valid) begin
                        w_gnt0 = 1'b1;
                    end
                end
                default: begin
                    if (req0.valid && req1.valid) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = req0.valid;
                        w_gnt1 = req1.valid;
                    end
                end
            endcase
        end

        w_any          = w_gnt0 | w_gnt1;
        w_win_lock     = w_gnt1 ? req1.lock : req0.lock;
        w_win_wr       = w_gnt1 ? req1.wr : req0.wr;
        w_peer_vld     = w_gnt1 ? req0.valid : req1.valid;
        w_win_is_owner = (r_owner == OWN_0 && w_gnt0) || (r_owner == OWN_1 && w_gnt1);
        // Serving the peer of an idle owner is a courtesy slot: ownership and count are untouched.
        w_idle_serve   = (r_owner != OWN_NONE) && w_any && !w_win_is_owner && !w_forced;

        if (w_any) begin
            w_last_nxt = w_gnt1;
            if (!w_idle_serve) begin
                if (w_win_lock) begin
                    w_owner_nxt    = w_gnt1 ? OWN_1 : OWN_0;
                    // A new owner starts a fresh run of consecutive grants.
                    w_cnt_base     = w_win_is_owner ? r_lock_cnt : 4'd0;
                    w_lock_cnt_nxt = (w_peer_vld && w_cnt_base != C_LOCK_MAX) ?
                                     w_cnt_base + 4'd1 : w_cnt_base;
                end else begin
                    w_owner_nxt    = OWN_NONE;
                    w_lock_cnt_nxt = 4'd0;
                end
            end
        end

        w_pend_vld_nxt = w_any & ~w_win_wr;
        w_pend_id_nxt  = w_gnt1;
    end

    assign req0.ready     = w_gnt0;
    assign req1.ready     = w_gnt1;

    assign ram_wr         = w_any & w_win_wr;
    assign ram_addr       = w_gnt1 ? req1.addr : req0.addr;
    assign ram_din        = w_gnt1 ? req1.din : req0.din;

    assign req0.rsp_valid = r_pend_vld & ~r_pend_id;
    assign req1.rsp_valid = r_pend_vld & r_pend_id;
    assign req0.rsp_data  = ram_dout;
    assign req1.rsp_data  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dpram_port_arbiter
// Random and directed stimulus against a queue-based scoreboard and RAM model.
// Rev    : 1.0
// ============================================================================
module tb_dpram_port_arbiter;
    localparam int DATA     = 8;
    localparam int ADDR     = 10;
    localparam int LOCK_MAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ram_wr;
    logic [ADDR-1:0] ram_addr;
    logic [DATA-1:0] ram_din;
    logic [DATA-1:0] ram_dout;

    dpram_port_arbiter_if #(.DATA(DATA), .ADDR(ADDR)) u_req0 ();
    dpram_port_arbiter_if #(.DATA(DATA), .ADDR(ADDR)) u_req1 ();

    dpram_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .LOCK_MAX(LOCK_MAX)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (u_req0),
        .req1     (u_req1),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Attached RAM port: registered read, write-first.
    logic [DATA-1:0] ram_mem [1024];
    always @(posedge clk) begin
        if (ram_wr) begin
            ram_mem[ram_addr] <= ram_din;
            ram_dout          <= ram_din;
        end else begin
            ram_dout <= ram_mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Requester stimulus held in arrays so either side can be indexed by id.
    bit              tv  [2];
    bit              twr [2];
    bit              tlk [2];
    logic [ADDR-1:0] ta  [2];
    logic [DATA-1:0] td  [2];

    task automatic apply();
        u_req0.valid = tv[0]; u_req0.wr = twr[0]; u_req0.lock = tlk[0];
        u_req0.addr  = ta[0]; u_req0.din = td[0];
        u_req1.valid = tv[1]; u_req1.wr = twr[1]; u_req1.lock = tlk[1];
        u_req1.addr  = ta[1]; u_req1.din = td[1];
    endtask

    // Reference model: arbitration rules, memory contents and expected responses.
    typedef struct {
        int              id;
        logic [DATA-1:0] data;
        bit              known;
        int              due;
    } exp_t;

    exp_t            q[$];
    int              m_owner;
    int              m_last;
    int              m_cnt;
    logic [DATA-1:0] m_mem   [1024];
    bit              m_known [1024];

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_cnt   = 0;
    endtask

    task automatic step(output int win);
        bit   forced;
        bit   idle;
        int   o;
        int   base;
        exp_t e;
        @(negedge clk);
        apply();
        #1;
        win    = -1;
        forced = 0;
        if (m_owner < 0) begin
            if (tv[0] && tv[1]) win = 1 - m_last;
            else if (tv[0])     win = 0;
            else if (tv[1])     win = 1;
        end else begin
            o = m_owner;
            if (tv[o] && tv[1-o] && m_cnt == LOCK_MAX) begin
                win    = 1 - o;
                forced = 1;
            end else if (tv[o]) begin
                win = o;
            end else if (tv[1-o]) begin
                win = 1 - o;
            end
        end

        chk("ready0", 32'(u_req0.ready), 32'(win == 0));
        chk("ready1", 32'(u_req1.ready), 32'(win == 1));
        if (win >= 0) begin
            chk("ram_wr", 32'(ram_wr), 32'(twr[win]));
            chk("ram_addr", 32'(ram_addr), 32'(ta[win]));
            if (twr[win]) chk("ram_din", 32'(ram_din), 32'(td[win]));
        end else begin
            chk("ram_wr_idle", 32'(ram_wr), 32'd0);
            chk("ram_addr_idle", 32'(ram_addr), 32'(ta[0]));
        end

        if (win >= 0) begin
            idle   = (m_owner >= 0) && (win != m_owner) && !forced;
            m_last = win;
            if (!idle) begin
                if (tlk[win]) begin
                    base    = (m_owner == win) ? m_cnt : 0;
                    m_owner = win;
                    m_cnt   = (tv[1-win] && base < LOCK_MAX) ? base + 1 : base;
                end else begin
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
            if (twr[win]) begin
                m_mem[ta[win]]   = td[win];
                m_known[ta[win]] = 1;
            end else begin
                e.id    = win;
                e.data  = m_mem[ta[win]];
                e.known = m_known[ta[win]];
                e.due   = cyc + 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tv[0] = 0; tv[1] = 0;
        apply();
        @(negedge clk);
        #2;
        rst = 1;
        q.delete();
        model_reset();
        @(negedge clk);
        #2;
        rst = 0;
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input bit l,
                           input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
        tv[i] = v; twr[i] = w; tlk[i] = l; ta[i] = a; td[i] = d;
    endtask

    // Scoreboard monitor: every presented response must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (u_req0.rsp_valid && u_req1.rsp_valid) fail("rsp_both_valid");
        if (u_req0.rsp_valid || u_req1.rsp_valid) begin
            if (q.size() == 0) begin
                fail("rsp_unexpected");
            end else begin
                e = q.pop_front();
                chk("rsp_id", 32'(u_req1.rsp_valid), 32'(e.id));
                chk("rsp_due", 32'(cyc), 32'(e.due));
                if (e.known)
                    chk("rsp_data", 32'(u_req1.rsp_valid ? u_req1.rsp_data : u_req0.rsp_data),
                        32'(e.data));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            fail("rsp_missing");
            void'(q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         win;
        int         last_win;
        logic [9:0] seq;

        model_reset();
        rst = 1;
        set_req(0, 1, 1, 0, 10'h000, 8'h11);
        set_req(1, 1, 1, 0, 10'h001, 8'h22);
        apply();
        #1;
        chk("rst_ready0", 32'(u_req0.ready), 32'd0);
        chk("rst_ready1", 32'(u_req1.ready), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_rsp0", 32'(u_req0.rsp_valid), 32'd0);
        chk("rst_rsp1", 32'(u_req1.rsp_valid), 32'd0);
        @(negedge clk);
        tv[0] = 0; tv[1] = 0;
        apply();
        #2;
        rst = 0;

        // Single requester write then read.
        set_req(1, 0, 0, 0, 10'h000, 8'h00);
        set_req(0, 1, 1, 0, 10'h010, 8'hA5);
        step(win);
        chk("single_wr_ready0", 32'(u_req0.ready), 32'd1);
        set_req(0, 1, 0, 0, 10'h010, 8'h00);
        step(win);
        chk("single_rd_ready0", 32'(u_req0.ready), 32'd1);

        // Write by requester 1, read by requester 0 the next cycle.
        set_req(0, 0, 0, 0, 10'h010, 8'h00);
        set_req(1, 1, 1, 0, 10'h3FF, 8'h3C);
        step(win);
        set_req(1, 0, 0, 0, 10'h000, 8'h00);
        set_req(0, 1, 0, 0, 10'h3FF, 8'h00);
        step(win);

        // Contention from reset: both stream reads.
        do_reset();
        seq = '0;
        set_req(0, 1, 0, 0, 10'h010, 8'h00);
        set_req(1, 1, 0, 0, 10'h3FF, 8'h00);
        for (int n = 0; n < 4; n++) begin
            step(win);
            seq = {seq[8:0], u_req1.ready};
        end
        chk("contention_seq", 32'(seq[3:0]), 32'b0101);

        // Bounded lock: requester 0 locked, requester 1 waiting.
        do_reset();
        seq = '0;
        set_req(0, 1, 0, 1, 10'h010, 8'h00);
        set_req(1, 1, 0, 0, 10'h3FF, 8'h00);
        for (int n = 0; n < 10; n++) begin
            step(win);
            seq = {seq[8:0], u_req1.ready};
        end
        chk("lock_seq", 32'(seq), 32'b0000100001);

        // Locked owner goes idle for one cycle.
        do_reset();
        seq = '0;
        set_req(0, 1, 0, 1, 10'h010, 8'h00);
        set_req(1, 1, 0, 0, 10'h3FF, 8'h00);
        step(win);
        seq = {seq[8:0], u_req1.ready};
        tv[0] = 0;
        step(win);
        seq = {seq[8:0], u_req1.ready};
        tv[0] = 1;
        step(win);
        seq = {seq[8:0], u_req1.ready};
        chk("idle_owner_seq", 32'(seq[2:0]), 32'b010);

        // Reset in the cycle after an accepted read drops the response.
        do_reset();
        set_req(1, 0, 0, 0, 10'h000, 8'h00);
        set_req(0, 1, 0, 0, 10'h010, 8'h00);
        step(win);
        @(posedge clk);
        #1;
        rst = 1;
        q.delete();
        model_reset();
        set_req(0, 1, 1, 0, 10'h010, 8'hFF);
        apply();
        #1;
        chk("midrst_rsp0", 32'(u_req0.rsp_valid), 32'd0);
        chk("midrst_rsp1", 32'(u_req1.rsp_valid), 32'd0);
        chk("midrst_ready0", 32'(u_req0.ready), 32'd0);
        chk("midrst_ram_wr", 32'(ram_wr), 32'd0);
        @(negedge clk);
        tv[0] = 0;
        apply();
        #2;
        rst = 0;
        set_req(0, 1, 0, 0, 10'h010, 8'h00);
        set_req(1, 1, 0, 0, 10'h3FF, 8'h00);
        step(win);
        chk("post_rst_tie_ready0", 32'(u_req0.ready), 32'd1);

        // Randomized traffic; a request is held until its grant.
        do_reset();
        last_win = -1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!tv[i] || last_win == i) begin
                    tv[i]  = ($urandom_range(0, 3) != 0);
                    twr[i] = ($urandom_range(0, 2) == 0);
                    tlk[i] = ($urandom_range(0, 3) == 0);
                    ta[i]  = 10'h040 + 10'($urandom_range(0, 15));
                    td[i]  = 8'($urandom);
                end
            end
            step(last_win);
        end

        tv[0] = 0; tv[1] = 0;
        for (int n = 0; n < 3; n++) step(win);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
